// File: rtl/sdram_arbiter_module_if.sv
// Client request/grant bus plus the sub-module strobes of the SDRAM command arbiter.
// The arbiter sits on the slave modport and the clients/sub-modules on the master modport.
interface sdram_arbiter_module_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] WrEN_Sig;
    logic [NCH-1:0] RdEN_Sig;
    logic [NCH-1:0] Grant_Sig;
    logic [NCH-1:0] Done_Sig;
    logic           Busy_Sig;
    logic           Init_Done_Sig;
    logic           Func_Done_Sig;
    logic           AR_Done_Sig;
    logic           Init_Start_Sig;
    logic [2:0]     Func_Start_Sig;
    logic [2:0]     Ref_Pend;
    logic           Ref_Ovf_Sig;
    logic [2:0]     state_dbg;

    // Handshake: a channel raises RdEN/WrEN and holds it until its Done_Sig pulse;
    // each start strobe is held high until the matching done strobe is seen on a clock edge.
    modport slave (
        input  WrEN_Sig, RdEN_Sig, Init_Done_Sig, Func_Done_Sig, AR_Done_Sig,
        output Grant_Sig, Done_Sig, Busy_Sig, Init_Start_Sig, Func_Start_Sig,
               Ref_Pend, Ref_Ovf_Sig, state_dbg
    );

    modport master (
        output WrEN_Sig, RdEN_Sig, Init_Done_Sig, Func_Done_Sig, AR_Done_Sig,
        input  Grant_Sig, Done_Sig, Busy_Sig, Init_Start_Sig, Func_Start_Sig,
               Ref_Pend, Ref_Ovf_Sig, state_dbg
    );
endinterface

// File: rtl/sdram_arbiter_module.sv
// SDRAM command arbiter: power-up init, periodic auto-refresh with a bounded
// postponement backlog, and round-robin grant of the shared read/write engine.
module sdram_arbiter_module #(
    parameter int NCH        = 4,
    parameter int REF_CYCLES = 100,
    parameter int REF_W      = 16,
    parameter int MAX_PEND   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    sdram_arbiter_module_if.slave bus
);
    localparam int              PW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [2:0]      PEND_MAX = 3'(MAX_PEND);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_AREF = 3'd2,
        S_FUNC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic             win_found;
    logic             rd_sel;
    logic             init_armed;
    logic [REF_W-1:0] ref_cnt;
    logic [2:0]       ref_pend;
    logic             ref_ovf;
    logic             tick;
    logic             ar_dec;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   ptr_oh;

    assign req    = bus.WrEN_Sig | bus.RdEN_Sig;
    assign ptr_oh = NCH'(1) << ptr;
    assign tick   = (state != S_INIT) && (ref_cnt == REF_LAST);
    assign ar_dec = (state == S_AREF) && bus.AR_Done_Sig;

    // Round-robin search starts one past the last winner and wraps.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = ptr;
        win_found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!win_found && req[idx[PW-1:0]]) begin
                winner    = idx[PW-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_INIT;
        else     state <= state_nxt;
    end

    // A full backlog outranks clients; a partial one only fills idle time.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (bus.Init_Done_Sig) state_nxt = S_IDLE;
            S_IDLE: begin
                if (ref_pend == PEND_MAX)  state_nxt = S_AREF;
                else if (win_found)        state_nxt = S_FUNC;
                else if (ref_pend != 3'd0) state_nxt = S_AREF;
            end
            S_AREF: if (bus.AR_Done_Sig)   state_nxt = S_IDLE;
            S_FUNC: if (bus.Func_Done_Sig) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        bus.Grant_Sig      = '0;
        bus.Done_Sig       = '0;
        bus.Func_Start_Sig = 3'b000;
        bus.Busy_Sig       = 1'b0;
        bus.Init_Start_Sig = 1'b0;
        case (state)
            S_INIT: begin
                bus.Busy_Sig       = 1'b1;
                bus.Init_Start_Sig = init_armed;
            end
            S_AREF: bus.Func_Start_Sig = 3'b100;
            S_FUNC: begin
                bus.Grant_Sig      = ptr_oh;
                bus.Func_Start_Sig = rd_sel ? 3'b010 : 3'b001;
            end
            S_DONE: begin
                bus.Grant_Sig = ptr_oh;
                bus.Done_Sig  = ptr_oh;
            end
            default: ;
        endcase
    end

    assign bus.Ref_Pend    = ref_pend;
    assign bus.Ref_Ovf_Sig = ref_ovf;
    assign bus.state_dbg   = state;

    // init_armed delays Init_Start by one edge so it stays low while RST is held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr        <= '0;
            rd_sel     <= 1'b0;
            init_armed <= 1'b0;
            ref_cnt    <= '0;
            ref_pend   <= 3'd0;
            ref_ovf    <= 1'b0;
        end else begin
            init_armed <= 1'b1;
            if (state == S_IDLE && state_nxt == S_FUNC) begin
                ptr    <= winner;
                rd_sel <= bus.RdEN_Sig[winner];
            end
            if (state == S_INIT || tick) ref_cnt <= '0;
            else                         ref_cnt <= ref_cnt + 1'b1;
            // A tick and a completed refresh in the same cycle cancel out.
            if (tick && !ar_dec) begin
                if (ref_pend == PEND_MAX) ref_ovf  <= 1'b1;
                else                      ref_pend <= ref_pend + 3'd1;
            end else if (ar_dec && !tick) begin
                ref_pend <= ref_pend - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_arbiter_module.sv
// Directed bench for sdram_arbiter_module: grants are pushed into an expected
// queue by the stimulus and popped by a monitor whenever a new grant appears.
module tb_sdram_arbiter_module;
    localparam int NCH = 4;
    localparam int REFC = 10;
    localparam int MAXP = 2;
    localparam int EW = NCH + 3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   init_edge = 0;
    int   init_hi_cnt = 0;
    int   aref_busy_cnt = 0;
    int   aref_idle_cnt = 0;

    logic [EW-1:0] exp_q[$];
    logic [NCH-1:0] wr_mode, rd_mode;
    int   cnt_issued[NCH];
    int   cnt_done[NCH];
    logic ar_resp, ar_force, ar_hold;

    sdram_arbiter_module_if #(.NCH(NCH)) bus ();

    sdram_arbiter_module #(
        .NCH(NCH), .REF_CYCLES(REFC), .REF_W(4), .MAX_PEND(MAXP)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // Clock and cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic [2:0] fs, input logic [NCH-1:0] g);
        exp_q.push_back({fs, g});
    endtask

    task automatic issue(input int ch, input logic rd, input logic wr, input int n);
        rd_mode[ch] = rd;
        wr_mode[ch] = wr;
        cnt_issued[ch] = cnt_issued[ch] + n;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((bus.WrEN_Sig | bus.RdEN_Sig) == '0) return;
        end
        n_checks++;
        $display("FAIL %s: requests still pending after 600 cycles", name);
    endtask

    // Request levels: held while a channel has issued accesses not yet completed
    always_comb begin
        bus.WrEN_Sig = '0;
        bus.RdEN_Sig = '0;
        for (int c = 0; c < NCH; c++) begin
            bus.WrEN_Sig[c] = wr_mode[c] && (cnt_issued[c] > cnt_done[c]);
            bus.RdEN_Sig[c] = rd_mode[c] && (cnt_issued[c] > cnt_done[c]);
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) cnt_done[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++)
                if (bus.Done_Sig[c]) cnt_done[c] = cnt_done[c] + 1;
        end
    end

    // Function engine: done 5 cycles after start
    initial begin
        bus.Func_Done_Sig = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.Func_Start_Sig[1:0] != 2'b00) begin
                repeat (4) @(negedge clk);
                bus.Func_Done_Sig = 1'b1;
                @(negedge clk);
                bus.Func_Done_Sig = 1'b0;
            end
        end
    end

    // Refresh engine: done 3 cycles after start unless held
    assign bus.AR_Done_Sig = ar_resp | ar_force;
    initial begin
        ar_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.Func_Start_Sig == 3'b100) begin
                repeat (2) @(negedge clk);
                while (ar_hold) @(negedge clk);
                ar_resp = 1'b1;
                @(negedge clk);
                ar_resp = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.Init_Start_Sig) init_hi_cnt++;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [NCH-1:0] prev_grant, prev_done, last_grant;
        logic [2:0]     prev_fs;
        logic [EW-1:0]  e;
        prev_grant = '0;
        prev_done  = '0;
        last_grant = '0;
        prev_fs    = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.Grant_Sig != '0 && prev_grant == '0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL grant: unexpected grant %0h fs %0h", bus.Grant_Sig, bus.Func_Start_Sig);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", {bus.Func_Start_Sig, bus.Grant_Sig}, e);
                        last_grant = e[NCH-1:0];
                    end
                end
                if (bus.Func_Start_Sig == 3'b100 && prev_fs != 3'b100) begin
                    if ((bus.WrEN_Sig | bus.RdEN_Sig) != '0) begin
                        chk("aref_busy_pend", bus.Ref_Pend, MAXP);
                        aref_busy_cnt++;
                    end else begin
                        chk("aref_idle_pend_nonzero", bus.Ref_Pend != 3'd0, 1);
                        aref_idle_cnt++;
                    end
                    chk("aref_no_grant", bus.Grant_Sig, 0);
                end
                if (bus.Done_Sig != '0) begin
                    chk("done_ch", bus.Done_Sig, last_grant);
                    chk("done_grant", bus.Grant_Sig, last_grant);
                end
                if (prev_done != '0) chk("done_pulse", {bus.Done_Sig, bus.Grant_Sig}, 0);
            end
            prev_grant = bus.Grant_Sig;
            prev_done  = bus.Done_Sig;
            prev_fs    = bus.Func_Start_Sig;
        end
    end

    // Directed stimulus
    initial begin
        rst = 1'b1;
        bus.Init_Done_Sig = 1'b0;
        ar_force = 1'b0;
        ar_hold  = 1'b0;
        wr_mode  = '0;
        rd_mode  = '0;
        for (int c = 0; c < NCH; c++) cnt_issued[c] = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.Busy_Sig, 1);
        chk("rst_init_start", bus.Init_Start_Sig, 0);
        chk("rst_outputs", {bus.Grant_Sig, bus.Done_Sig, bus.Func_Start_Sig}, 0);
        chk("rst_ref", {bus.Ref_Pend, bus.Ref_Ovf_Sig}, 0);
        rst = 1'b0;

        @(negedge clk);
        chk("init_start_rise", bus.Init_Start_Sig, 1);
        chk("init_busy", bus.Busy_Sig, 1);
        repeat (19) @(negedge clk);
        bus.Init_Done_Sig = 1'b1;
        init_edge = cyc + 1;
        @(negedge clk);
        bus.Init_Done_Sig = 1'b0;
        chk("init_busy_low", bus.Busy_Sig, 0);
        chk("init_start_low", bus.Init_Start_Sig, 0);
        chk("init_ref_pend", bus.Ref_Pend, 0);
        chk("init_start_cycles", init_hi_cnt, 20);

        // Read beats write on the same channel
        issue(1, 1'b1, 1'b1, 1);
        push(3'b010, 4'b0010);
        wait_idle("read_prio");

        issue(3, 1'b0, 1'b1, 1);
        push(3'b001, 4'b1000);
        wait_idle("ch3_write");

        // Round robin over channels 0,2,3 starting after channel 3
        issue(0, 1'b0, 1'b1, 2);
        issue(2, 1'b0, 1'b1, 1);
        issue(3, 1'b0, 1'b1, 1);
        push(3'b001, 4'b0001);
        push(3'b001, 4'b0100);
        push(3'b001, 4'b1000);
        push(3'b001, 4'b0001);
        wait_idle("round_robin");

        issue(0, 1'b0, 1'b1, 1);
        issue(2, 1'b1, 1'b0, 1);
        push(3'b010, 4'b0100);
        push(3'b001, 4'b0001);
        wait_idle("mixed_rw");

        // Continuous traffic forces a deferred refresh
        issue(0, 1'b0, 1'b1, 4);
        issue(1, 1'b0, 1'b1, 4);
        for (int i = 0; i < 4; i++) begin
            push(3'b001, 4'b0010);
            push(3'b001, 4'b0001);
        end
        wait_idle("continuous");
        chk("aref_deferred_seen", aref_busy_cnt > 0, 1);
        chk("ovf_clear_before", bus.Ref_Ovf_Sig, 0);

        // Stall refresh completion until the backlog saturates
        ar_hold = 1'b1;
        repeat (45) @(negedge clk);
        chk("ovf_pend_sat", bus.Ref_Pend, MAXP);
        chk("ovf_set", bus.Ref_Ovf_Sig, 1);
        chk("ovf_aref_held", bus.Func_Start_Sig, 3'b100);
        for (int i = 0; i < REFC && ((cyc + 1 - init_edge) % REFC) != 0; i++) @(negedge clk);
        ar_force = 1'b1;
        @(negedge clk);
        ar_force = 1'b0;
        chk("simul_pend", bus.Ref_Pend, MAXP);
        chk("simul_fs_idle", bus.Func_Start_Sig, 0);
        ar_hold = 1'b0;
        for (int i = 0; i < 100 && !(bus.Ref_Pend == 3'd0 && bus.Func_Start_Sig == 3'b000); i++)
            @(negedge clk);
        chk("drain_pend", bus.Ref_Pend, 0);
        chk("ovf_sticky", bus.Ref_Ovf_Sig, 1);
        chk("aref_idle_seen", aref_idle_cnt > 0, 1);

        // Reset in the middle of an access
        issue(1, 1'b0, 1'b1, 1);
        push(3'b001, 4'b0010);
        for (int i = 0; i < 100 && bus.Grant_Sig == '0; i++) @(negedge clk);
        chk("midop_granted", bus.Grant_Sig, 4'b0010);
        rst = 1'b1;
        cnt_issued[1] = cnt_done[1];
        @(negedge clk);
        chk("midop_grant", bus.Grant_Sig, 0);
        chk("midop_fs", bus.Func_Start_Sig, 0);
        chk("midop_busy", bus.Busy_Sig, 1);
        chk("midop_ovf", bus.Ref_Ovf_Sig, 0);
        chk("midop_pend", bus.Ref_Pend, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus.Init_Done_Sig = 1'b1;
        @(negedge clk);
        bus.Init_Done_Sig = 1'b0;

        // Pointer restarts at 0: channel 1 is searched before channel 0
        issue(0, 1'b0, 1'b1, 1);
        issue(1, 1'b0, 1'b1, 1);
        push(3'b001, 4'b0010);
        push(3'b001, 4'b0001);
        wait_idle("post_reset");

        repeat (20) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
